// File: rtl/csc_pkg.sv
// Shared types and constants for the csc_stor row scheduler.
package csc_pkg;

    localparam int unsigned VAL_W   = 32;
    localparam int unsigned NNZ_MAX = 4;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        EMIT,
        DONE
    } state_t;

    // Job descriptor fields held for csc_stor while a job is in flight
    typedef struct packed {
        logic [VAL_W-1:0] z0;
        logic [VAL_W-1:0] z1;
        logic [VAL_W-1:0] s_i;
        logic [VAL_W-1:0] s_r;
        logic [VAL_W-1:0] a0_i;
        logic [VAL_W-1:0] a0_r;
        logic [VAL_W-1:0] a1_i;
        logic [VAL_W-1:0] a1_r;
    } job_t;

    function automatic int unsigned idx_w(input int unsigned rank);
        return $clog2(rank);
    endfunction

endpackage

// File: rtl/csc_col_rot.sv
// Circulant rotation of four packed column indices; entries at or above nnz read as zero.
module csc_col_rot
    import csc_pkg::*;
#(
    parameter int unsigned INDEX_W = 8
) (
    input  logic [NNZ_MAX*INDEX_W-1:0] col_in,
    input  logic [INDEX_W-1:0]         offset,
    input  logic [2:0]                 nnz,
    output logic [NNZ_MAX*INDEX_W-1:0] col_out_c
);

    // Index width equals log2(rank), so the plain add wraps modulo the rank.
    always_comb begin
        col_out_c = '0;
        for (int k = 0; k < int'(NNZ_MAX); k++) begin
            if (k < int'(nnz)) begin
                col_out_c[k*INDEX_W +: INDEX_W] = col_in[k*INDEX_W +: INDEX_W] + offset;
            end
        end
    end

endmodule

// File: rtl/csc_row_sched.sv
// Issues one job to csc_stor, captures its first row, and streams NUM_ROWS circulant rows.
module csc_row_sched
    import csc_pkg::*;
#(
    parameter int unsigned MAT_RANK = 256,
    parameter int unsigned NUM_ROWS = MAT_RANK,
    parameter int unsigned INDEX_W  = idx_w(MAT_RANK)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         job_vld,
    output logic                         job_rdy,
    input  logic [31:0]                  job_z0,
    input  logic [31:0]                  job_z1,
    input  logic [31:0]                  job_s_i,
    input  logic [31:0]                  job_s_r,
    input  logic [31:0]                  job_a0_i,
    input  logic [31:0]                  job_a0_r,
    input  logic [31:0]                  job_a1_i,
    input  logic [31:0]                  job_a1_r,
    output logic [31:0]                  stor_z0,
    output logic [31:0]                  stor_z1,
    output logic [31:0]                  stor_s_i,
    output logic [31:0]                  stor_s_r,
    output logic [31:0]                  stor_a0_i,
    output logic [31:0]                  stor_a0_r,
    output logic [31:0]                  stor_a1_i,
    output logic [31:0]                  stor_a1_r,
    output logic                         stor_vld,
    input  logic                         stor_rdy,
    input  logic [NNZ_MAX*INDEX_W-1:0]   stor_col_index,
    input  logic [2*NNZ_MAX*VAL_W-1:0]   stor_val,
    input  logic                         stor_res_vld,
    output logic                         stor_res_rdy,
    input  logic                         abort,
    output logic                         row_vld,
    input  logic                         row_rdy,
    output logic [INDEX_W-1:0]           row_idx,
    output logic [NNZ_MAX*INDEX_W-1:0]   row_col_index,
    output logic [2*NNZ_MAX*VAL_W-1:0]   row_val,
    output logic [2:0]                   row_nnz,
    output logic                         row_last,
    output logic                         busy,
    output logic                         job_done
);

    localparam int unsigned COL_W  = NNZ_MAX * INDEX_W;
    localparam int unsigned VEC_W  = 2 * NNZ_MAX * VAL_W;
    localparam int unsigned HALF_W = VEC_W / 2;
    localparam logic [INDEX_W-1:0] LAST_ROW = INDEX_W'(NUM_ROWS - 1);
    localparam logic [VEC_W-1:0]   LOW_MASK = {{HALF_W{1'b0}}, {HALF_W{1'b1}}};

    state_t             state_q, state_d;
    job_t               job_q, job_d;
    logic               eq_q, eq_d;
    logic               abort_pend_q, abort_pend_d;
    logic [INDEX_W-1:0] cnt_q, cnt_d;
    logic [COL_W-1:0]   cap_col_q, cap_col_d;
    logic [COL_W-1:0]   rot_col_c;
    logic [2:0]         nnz_c;
    logic               capture_c;

    assign nnz_c     = eq_q ? 3'd2 : 3'd4;
    assign capture_c = (state_q == WAIT) && stor_res_vld;

    assign stor_z0   = job_q.z0;
    assign stor_z1   = job_q.z1;
    assign stor_s_i  = job_q.s_i;
    assign stor_s_r  = job_q.s_r;
    assign stor_a0_i = job_q.a0_i;
    assign stor_a0_r = job_q.a0_r;
    assign stor_a1_i = job_q.a1_i;
    assign stor_a1_r = job_q.a1_r;

    // Rotation is fed with next-cycle base and offset so row outputs can be registered.
    csc_col_rot #(
        .INDEX_W (INDEX_W)
    ) u_col_rot (
        .col_in    (cap_col_d),
        .offset    (cnt_d),
        .nnz       (nnz_c),
        .col_out_c (rot_col_c)
    );

    // Next-state and datapath next values
    always_comb begin
        state_d      = state_q;
        job_d        = job_q;
        eq_d         = eq_q;
        abort_pend_d = abort_pend_q;
        cnt_d        = cnt_q;
        cap_col_d    = cap_col_q;
        case (state_q)
            IDLE: begin
                if (job_vld && job_rdy) begin
                    job_d        = '{z0: job_z0, z1: job_z1, s_i: job_s_i, s_r: job_s_r,
                                     a0_i: job_a0_i, a0_r: job_a0_r,
                                     a1_i: job_a1_i, a1_r: job_a1_r};
                    eq_d         = (job_z0 == job_z1);
                    abort_pend_d = 1'b0;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (abort) abort_pend_d = 1'b1;
                if (stor_rdy) state_d = WAIT;
            end
            WAIT: begin
                if (abort) abort_pend_d = 1'b1;
                if (stor_res_vld) begin
                    cap_col_d = stor_col_index;
                    cnt_d     = '0;
                    state_d   = (abort_pend_q || abort) ? DONE : EMIT;
                end
            end
            EMIT: begin
                if (row_rdy) begin
                    cnt_d = cnt_q + INDEX_W'(1);
                    if (cnt_q == LAST_ROW) state_d = DONE;
                end
                if (abort) state_d = DONE;
            end
            DONE: begin
                abort_pend_d = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            job_q         <= '0;
            eq_q          <= 1'b0;
            abort_pend_q  <= 1'b0;
            cnt_q         <= '0;
            cap_col_q     <= '0;
            job_rdy       <= 1'b1;
            stor_vld      <= 1'b0;
            stor_res_rdy  <= 1'b0;
            row_vld       <= 1'b0;
            row_idx       <= '0;
            row_col_index <= '0;
            row_val       <= '0;
            row_nnz       <= '0;
            row_last      <= 1'b0;
            busy          <= 1'b0;
            job_done      <= 1'b0;
        end else begin
            state_q      <= state_d;
            job_q        <= job_d;
            eq_q         <= eq_d;
            abort_pend_q <= abort_pend_d;
            cnt_q        <= cnt_d;
            cap_col_q    <= cap_col_d;
            job_rdy      <= (state_d == IDLE);
            stor_vld     <= (state_d == ISSUE);
            stor_res_rdy <= (state_d == WAIT);
            row_vld      <= (state_d == EMIT);
            busy         <= (state_d != IDLE);
            job_done     <= (state_d == DONE);
            if (state_d == EMIT) begin
                row_idx       <= cnt_d;
                row_col_index <= rot_col_c;
                row_last      <= (cnt_d == LAST_ROW);
            end else begin
                row_last      <= 1'b0;
            end
            if (capture_c) begin
                row_val <= eq_q ? (stor_val & LOW_MASK) : stor_val;
                row_nnz <= nnz_c;
            end
        end
    end

endmodule

// File: tb/tb_csc_row_sched.sv
// Directed self-checking bench for csc_row_sched with a scripted csc_stor stub.
module tb_csc_row_sched;

    localparam int unsigned MAT_RANK = 256;
    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned INDEX_W  = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         job_vld = 1'b0, job_rdy;
    logic [31:0]  job_z0 = '0, job_z1 = '0, job_s_i = '0, job_s_r = '0;
    logic [31:0]  job_a0_i = '0, job_a0_r = '0, job_a1_i = '0, job_a1_r = '0;
    logic [31:0]  stor_z0, stor_z1, stor_s_i, stor_s_r;
    logic [31:0]  stor_a0_i, stor_a0_r, stor_a1_i, stor_a1_r;
    logic         stor_vld, stor_rdy = 1'b0;
    logic [31:0]  stor_col_index = '0;
    logic [255:0] stor_val = '0;
    logic         stor_res_vld = 1'b0, stor_res_rdy;
    logic         abort = 1'b0;
    logic         row_vld, row_rdy = 1'b0;
    logic [7:0]   row_idx;
    logic [31:0]  row_col_index;
    logic [255:0] row_val;
    logic [2:0]   row_nnz;
    logic         row_last, busy, job_done;

    int n_vec = 0;
    int n_err = 0;
    logic [255:0] val_a;

    always #5 clk = ~clk;

    csc_row_sched #(
        .MAT_RANK (MAT_RANK),
        .NUM_ROWS (NUM_ROWS),
        .INDEX_W  (INDEX_W)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .job_vld (job_vld), .job_rdy (job_rdy),
        .job_z0 (job_z0), .job_z1 (job_z1), .job_s_i (job_s_i), .job_s_r (job_s_r),
        .job_a0_i (job_a0_i), .job_a0_r (job_a0_r), .job_a1_i (job_a1_i), .job_a1_r (job_a1_r),
        .stor_z0 (stor_z0), .stor_z1 (stor_z1), .stor_s_i (stor_s_i), .stor_s_r (stor_s_r),
        .stor_a0_i (stor_a0_i), .stor_a0_r (stor_a0_r), .stor_a1_i (stor_a1_i), .stor_a1_r (stor_a1_r),
        .stor_vld (stor_vld), .stor_rdy (stor_rdy),
        .stor_col_index (stor_col_index), .stor_val (stor_val),
        .stor_res_vld (stor_res_vld), .stor_res_rdy (stor_res_rdy),
        .abort (abort),
        .row_vld (row_vld), .row_rdy (row_rdy), .row_idx (row_idx),
        .row_col_index (row_col_index), .row_val (row_val), .row_nnz (row_nnz),
        .row_last (row_last), .busy (busy), .job_done (job_done)
    );

    // Starts at a negedge in IDLE, returns at the negedge where the DUT sits in WAIT
    task automatic issue_job(input logic [31:0] z0, input logic [31:0] z1);
        job_z0 = z0; job_z1 = z1;
        job_s_i = 32'h0000_4000; job_s_r = 32'h0001_8000;
        job_a0_i = 32'h0002_0000; job_a0_r = 32'h0003_0000;
        job_a1_i = 32'h0004_0000; job_a1_r = 32'h0005_0000;
        stor_rdy = 1'b1;
        job_vld = 1'b1;
        @(negedge clk);
        job_vld = 1'b0;
        @(negedge clk);
    endtask

    // Presents one csc_stor result for a single cycle
    task automatic return_result(input logic [31:0] col, input logic [255:0] val);
        stor_col_index = col;
        stor_val = val;
        stor_res_vld = 1'b1;
        @(negedge clk);
        stor_res_vld = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({job_rdy, busy, stor_vld, stor_res_rdy, row_vld, row_last, job_done} !== 7'b1000000) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 1000000",
                     {job_rdy, busy, stor_vld, stor_res_rdy, row_vld, row_last, job_done});
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({row_nnz, row_idx, row_col_index, job_rdy, busy} !== {3'd0, 8'd0, 32'd0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL reset_outputs: got nnz=%0d idx=%0d col=%h rdy=%b busy=%b want 0 0 0 1 0",
                     row_nnz, row_idx, row_col_index, job_rdy, busy);
        end
    endtask

    task automatic test_basic;
        logic [31:0] exp_col;
        row_rdy = 1'b1;
        stor_rdy = 1'b1;
        job_z0 = 32'h0003_0000; job_z1 = 32'h0005_0000; job_s_r = 32'h0001_8000;
        job_vld = 1'b1;
        @(negedge clk);
        job_vld = 1'b0;
        n_vec++;
        if ({stor_vld, job_rdy, busy} !== 3'b101) begin
            n_err++;
            $display("FAIL basic_issue_flags: got vld/rdy/busy=%b want 101", {stor_vld, job_rdy, busy});
        end
        n_vec++;
        if ({stor_z0, stor_z1, stor_s_r} !== {32'h0003_0000, 32'h0005_0000, 32'h0001_8000}) begin
            n_err++;
            $display("FAIL basic_stor_fields: got %h %h %h want 00030000 00050000 00018000",
                     stor_z0, stor_z1, stor_s_r);
        end
        @(negedge clk);
        n_vec++;
        if ({stor_vld, stor_res_rdy} !== 2'b01) begin
            n_err++;
            $display("FAIL basic_wait_flags: got %b want 01", {stor_vld, stor_res_rdy});
        end
        return_result({8'd131, 8'd131, 8'd5, 8'd3}, val_a);
        for (int k = 0; k < 4; k++) begin
            exp_col = {8'(131 + k), 8'(131 + k), 8'(5 + k), 8'(3 + k)};
            n_vec++;
            if ({row_vld, row_last, row_idx, row_nnz} !== {1'b1, (k == 3), 8'(k), 3'd4}) begin
                n_err++;
                $display("FAIL basic_beat%0d_ctrl: got vld=%b last=%b idx=%0d nnz=%0d want 1 %b %0d 4",
                         k, row_vld, row_last, row_idx, row_nnz, (k == 3), k);
            end
            n_vec++;
            if ((row_col_index !== exp_col) || (row_val !== val_a)) begin
                n_err++;
                $display("FAIL basic_beat%0d_data: got col=%h val=%h want col=%h val=%h",
                         k, row_col_index, row_val, exp_col, val_a);
            end
            @(negedge clk);
        end
        n_vec++;
        if ({row_vld, job_done, job_rdy} !== 3'b010) begin
            n_err++;
            $display("FAIL basic_done: got vld/done/rdy=%b want 010", {row_vld, job_done, job_rdy});
        end
        @(negedge clk);
        n_vec++;
        if ({job_done, job_rdy, busy} !== 3'b010) begin
            n_err++;
            $display("FAIL basic_idle: got done/rdy/busy=%b want 010", {job_done, job_rdy, busy});
        end
    endtask

    task automatic test_equal;
        logic [31:0] exp_col [4];
        logic [255:0] exp_val;
        exp_col = '{32'h0000_9010, 32'h0000_9111, 32'h0000_9212, 32'h0000_9313};
        exp_val = {128'd0, val_a[127:0]};
        row_rdy = 1'b1;
        issue_job(32'h0010_0000, 32'h0010_0000);
        return_result({8'd0, 8'd0, 8'd144, 8'd16}, val_a);
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if ({row_vld, row_nnz, row_col_index, row_val} !== {1'b1, 3'd2, exp_col[k], exp_val}) begin
                n_err++;
                $display("FAIL equal_beat%0d: got vld=%b nnz=%0d col=%h val=%h want 1 2 %h %h",
                         k, row_vld, row_nnz, row_col_index, row_val, exp_col[k], exp_val);
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_wrap;
        logic [31:0] exp_col [4];
        exp_col = '{32'hFFFE_7F00, 32'h00FF_8001, 32'h0100_8102, 32'h0201_8203};
        row_rdy = 1'b1;
        issue_job(32'h0000_0000, 32'h00FE_0000);
        return_result({8'd255, 8'd254, 8'd127, 8'd0}, val_a);
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if ({row_vld, row_idx, row_col_index} !== {1'b1, 8'(k), exp_col[k]}) begin
                n_err++;
                $display("FAIL wrap_beat%0d: got vld=%b idx=%0d col=%h want 1 %0d %h",
                         k, row_vld, row_idx, row_col_index, k, exp_col[k]);
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        logic pat [4];
        int exp_row;
        int hs;
        logic [31:0] exp_col;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        exp_row = 0;
        hs = 0;
        row_rdy = 1'b0;
        issue_job(32'h000A_0000, 32'h0014_0000);
        return_result({8'd40, 8'd30, 8'd20, 8'd10}, val_a);
        for (int i = 0; i < 20; i++) begin
            if (exp_row == 4) break;
            exp_col = 32'h281E_140A + 32'(exp_row) * 32'h0101_0101;
            n_vec++;
            if ({row_vld, row_idx, row_col_index} !== {1'b1, 8'(exp_row), exp_col}) begin
                n_err++;
                $display("FAIL bp_cycle%0d: got vld=%b idx=%0d col=%h want 1 %0d %h",
                         i, row_vld, row_idx, row_col_index, exp_row, exp_col);
            end
            row_rdy = pat[i % 4];
            if (row_rdy) begin
                exp_row++;
                hs++;
            end
            @(negedge clk);
        end
        row_rdy = 1'b0;
        n_vec++;
        if ((hs != 4) || ({row_vld, job_done} !== 2'b01)) begin
            n_err++;
            $display("FAIL bp_end: got handshakes=%0d vld=%b done=%b want 4 0 1", hs, row_vld, job_done);
        end
        @(negedge clk);
    endtask

    task automatic test_abort_wait;
        row_rdy = 1'b1;
        issue_job(32'h0001_0000, 32'h0002_0000);
        abort = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            abort = 1'b0;
            n_vec++;
            if ({stor_res_rdy, row_vld, job_done} !== 3'b100) begin
                n_err++;
                $display("FAIL abort_wait_hold%0d: got resrdy/vld/done=%b want 100",
                         i, {stor_res_rdy, row_vld, job_done});
            end
        end
        return_result({8'd4, 8'd3, 8'd2, 8'd1}, val_a);
        n_vec++;
        if ({stor_res_rdy, row_vld, job_done} !== 3'b001) begin
            n_err++;
            $display("FAIL abort_wait_done: got resrdy/vld/done=%b want 001",
                     {stor_res_rdy, row_vld, job_done});
        end
        @(negedge clk);
        n_vec++;
        if ({row_vld, job_done, job_rdy} !== 3'b001) begin
            n_err++;
            $display("FAIL abort_wait_idle: got vld/done/rdy=%b want 001", {row_vld, job_done, job_rdy});
        end
    endtask

    task automatic test_abort_emit;
        row_rdy = 1'b1;
        issue_job(32'h0001_0000, 32'h0002_0000);
        return_result({8'd4, 8'd3, 8'd2, 8'd1}, val_a);
        @(negedge clk);
        n_vec++;
        if ({row_vld, row_idx} !== {1'b1, 8'd1}) begin
            n_err++;
            $display("FAIL abort_emit_beat1: got vld=%b idx=%0d want 1 1", row_vld, row_idx);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_vec++;
        if ({row_vld, job_done, busy} !== 3'b011) begin
            n_err++;
            $display("FAIL abort_emit_done: got vld/done/busy=%b want 011", {row_vld, job_done, busy});
        end
        @(negedge clk);
        n_vec++;
        if ({row_vld, job_done, job_rdy} !== 3'b001) begin
            n_err++;
            $display("FAIL abort_emit_idle: got vld/done/rdy=%b want 001", {row_vld, job_done, job_rdy});
        end
    endtask

    task automatic test_reset_mid;
        int seen_done;
        row_rdy = 1'b1;
        issue_job(32'h0001_0000, 32'h0002_0000);
        return_result({8'd4, 8'd3, 8'd2, 8'd1}, val_a);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({row_vld, job_rdy, busy, stor_res_rdy, job_done} !== 5'b01000) begin
            n_err++;
            $display("FAIL rst_mid_immediate: got vld/rdy/busy/resrdy/done=%b want 01000",
                     {row_vld, job_rdy, busy, stor_res_rdy, job_done});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({job_done, job_rdy, row_vld} !== 3'b010) begin
            n_err++;
            $display("FAIL rst_mid_after: got done/rdy/vld=%b want 010", {job_done, job_rdy, row_vld});
        end
        row_rdy = 1'b0;
        issue_job(32'h0003_0000, 32'h0005_0000);
        return_result({8'd131, 8'd131, 8'd5, 8'd3}, val_a);
        n_vec++;
        if ({row_vld, row_idx, row_col_index} !== {1'b1, 8'd0, 32'h8383_0503}) begin
            n_err++;
            $display("FAIL rst_mid_fresh: got vld=%b idx=%0d col=%h want 1 0 83830503",
                     row_vld, row_idx, row_col_index);
        end
        row_rdy = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (job_done) begin
                seen_done = 1;
                break;
            end
        end
        n_vec++;
        if (seen_done != 1) begin
            n_err++;
            $display("FAIL rst_mid_fresh_done: got job_done seen=%0d want 1", seen_done);
        end
        @(negedge clk);
    endtask

    initial begin
        val_a = {32'h40E0_0000, 32'h40C0_0000, 32'h40A0_0000, 32'h4080_0000,
                 32'h4040_0000, 32'h4000_0000, 32'h3FC0_0000, 32'h3F80_0000};
        test_reset();
        test_basic();
        test_equal();
        test_wrap();
        test_backpressure();
        test_abort_wait();
        test_abort_emit();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
